// File: rtl/flag_stack_unit.sv
// Processor status-flag register with masked writes, a save/restore stack,
// sticky stack-error flags and branch-condition evaluation.
module flag_stack_unit #(
    parameter  int NFLAGS = 2,
    parameter  int DEPTH  = 4,
    localparam int SW     = (NFLAGS > 1) ? $clog2(NFLAGS) : 1,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [NFLAGS-1:0] wr_mask,
    input  logic [NFLAGS-1:0] flags_in,
    input  logic              push,
    input  logic              pop,
    input  logic [SW-1:0]     cond_sel,
    input  logic              cond_inv,
    input  logic              err_clr,
    output logic [NFLAGS-1:0] flags_out,
    output logic              cond_true,
    output logic [CW-1:0]     depth,
    output logic              full,
    output logic              empty,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] stack_mem [DEPTH];
    logic [NFLAGS-1:0] flags_q;
    logic [NFLAGS-1:0] flags_wr;
    logic [NFLAGS-1:0] flags_next;
    logic [CW-1:0]     depth_q;
    logic [CW-1:0]     depth_m1;
    logic [CW-1:0]     depth_next;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;
    logic              do_push;
    logic              do_pop;
    logic              ovf_set;
    logic              unf_set;
    logic              cond_bit;
    logic              cond_valid;

    assign full  = (depth_q == CW'(DEPTH));
    assign empty = (depth_q == '0);

    // Simultaneous push and pop cancel: no stack movement and no error.
    assign do_push = push & ~pop & ~full;
    assign do_pop  = pop & ~push & ~empty;
    assign ovf_set = push & ~pop & full;
    assign unf_set = pop & ~push & empty;

    assign depth_m1 = depth_q - CW'(1);
    assign wr_idx   = depth_q[AW-1:0];
    assign rd_idx   = depth_m1[AW-1:0];

    assign flags_wr   = we ? ((flags_q & ~wr_mask) | (flags_in & wr_mask)) : flags_q;
    assign flags_next = do_pop ? stack_mem[rd_idx] : flags_wr;

    always_comb begin
        depth_next = depth_q;
        if (do_push) begin
            depth_next = depth_q + CW'(1);
        end else if (do_pop) begin
            depth_next = depth_m1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which is what lets a push store the old flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
            depth_q <= '0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            flags_q <= flags_next;
            depth_q <= depth_next;
            err_ovf <= ovf_set | (err_ovf & ~err_clr);
            err_unf <= unf_set | (err_unf & ~err_clr);
        end
    end

    // NOTE: the stack array has no reset; depth alone decides which entries
    // are valid, so clearing depth discards everything in one cycle.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            stack_mem[wr_idx] <= flags_q;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch forms.
    always_comb begin
        cond_bit   = 1'b0;
        cond_valid = 1'b0;
        for (int i = 0; i < NFLAGS; i++) begin
            if (cond_sel == SW'(i)) begin
                cond_bit   = flags_q[i];
                cond_valid = 1'b1;
            end
        end
    end

    assign cond_true = cond_valid & (cond_bit ^ cond_inv);
    assign flags_out = flags_q;
    assign depth     = depth_q;

endmodule

// File: tb/tb_flag_stack_unit.sv
// Directed bench for flag_stack_unit: a 2-flag main instance plus 4- and 3-flag
// instances for condition decoding.
module tb_flag_stack_unit;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    // Main instance: NFLAGS=2, DEPTH=4
    logic       m_we, m_push, m_pop, m_inv, m_clr;
    logic [1:0] m_mask, m_fin, m_flags;
    logic [0:0] m_sel;
    logic [2:0] m_depth;
    logic       m_cond, m_full, m_empty, m_ovf, m_unf;

    flag_stack_unit #(.NFLAGS(2), .DEPTH(4)) u_main (
        .clk(clk), .rst(rst), .we(m_we), .wr_mask(m_mask), .flags_in(m_fin),
        .push(m_push), .pop(m_pop), .cond_sel(m_sel), .cond_inv(m_inv),
        .err_clr(m_clr), .flags_out(m_flags), .cond_true(m_cond),
        .depth(m_depth), .full(m_full), .empty(m_empty),
        .err_ovf(m_ovf), .err_unf(m_unf)
    );

    // NFLAGS=4 instance
    logic       a_we, a_inv, a_cond, a_full, a_empty, a_ovf, a_unf;
    logic [3:0] a_mask, a_fin, a_flags;
    logic [1:0] a_sel;
    logic [2:0] a_depth;

    flag_stack_unit #(.NFLAGS(4), .DEPTH(4)) u_f4 (
        .clk(clk), .rst(rst), .we(a_we), .wr_mask(a_mask), .flags_in(a_fin),
        .push(1'b0), .pop(1'b0), .cond_sel(a_sel), .cond_inv(a_inv),
        .err_clr(1'b0), .flags_out(a_flags), .cond_true(a_cond),
        .depth(a_depth), .full(a_full), .empty(a_empty),
        .err_ovf(a_ovf), .err_unf(a_unf)
    );

    // NFLAGS=3 instance
    logic       b_we, b_inv, b_cond, b_full, b_empty, b_ovf, b_unf;
    logic [2:0] b_mask, b_fin, b_flags;
    logic [1:0] b_sel;
    logic [2:0] b_depth;

    flag_stack_unit #(.NFLAGS(3), .DEPTH(4)) u_f3 (
        .clk(clk), .rst(rst), .we(b_we), .wr_mask(b_mask), .flags_in(b_fin),
        .push(1'b0), .pop(1'b0), .cond_sel(b_sel), .cond_inv(b_inv),
        .err_clr(1'b0), .flags_out(b_flags), .cond_true(b_cond),
        .depth(b_depth), .full(b_full), .empty(b_empty),
        .err_ovf(b_ovf), .err_unf(b_unf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [1:0] mask, input logic [1:0] fin,
                         input logic push, input logic pop, input logic clr);
        m_we = we; m_mask = mask; m_fin = fin; m_push = push; m_pop = pop; m_clr = clr;
    endtask

    task automatic check_state(input string name, input logic [1:0] flags,
                               input logic [2:0] dep, input logic ovf, input logic unf);
        tests_run++;
        if (m_flags !== flags || m_depth !== dep || m_ovf !== ovf || m_unf !== unf) begin
            tests_failed++;
            $display("FAIL %s: flags=%b depth=%0d ovf=%b unf=%b, expected flags=%b depth=%0d ovf=%b unf=%b",
                     name, m_flags, m_depth, m_ovf, m_unf, flags, dep, ovf, unf);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0);
        a_we = 1'b1; a_mask = 4'hF; a_fin = 4'hF;
        b_we = 1'b1; b_mask = 3'h7; b_fin = 3'h7;
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        a_we = 1'b0; b_we = 1'b0;
        check_state("reset_main", 2'b00, 3'd0, 1'b0, 1'b0);
        tests_run++;
        if (m_empty !== 1'b1 || m_full !== 1'b0 || m_cond !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: empty=%b full=%b cond=%b, expected 1 0 0", m_empty, m_full, m_cond);
        end
        tests_run++;
        if (a_flags !== 4'h0 || b_flags !== 3'h0) begin
            tests_failed++;
            $display("FAIL reset_wide: f4=%b f3=%b, expected 0", a_flags, b_flags);
        end
    endtask

    task automatic test_write();
        drive(1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0);
        step();
        check_state("write_mask01", 2'b01, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0);
        step();
        check_state("write_mask10", 2'b11, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        check_state("write_hold", 2'b11, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_push_pop_write();
        drive(1'b1, 2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
        step();
        check_state("pp_setup", 2'b10, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0);
        step();
        check_state("pp_push_write", 2'b01, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0);
        step();
        check_state("pp_pop_overrides", 2'b10, 3'd0, 1'b0, 1'b0);
        tests_run++;
        if (m_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL pp_empty: empty=%b, expected 1", m_empty);
        end
    endtask

    task automatic test_overflow();
        logic [1:0] pushed [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        drive(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
        step();
        // Each push stores the current flags while the write loads the next value.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b11, (i < 4) ? pushed[i+1] : 2'd3, 1'b1, 1'b0, 1'b0);
            step();
            if (i == 3) check_state("ovf_fourth_push", 2'd3, 3'd4, 1'b0, 1'b0);
        end
        check_state("ovf_fifth_push", 2'd3, 3'd4, 1'b1, 1'b0);
        tests_run++;
        if (m_full !== 1'b1 || m_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_full: full=%b empty=%b, expected 1 0", m_full, m_empty);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
            step();
            tests_run++;
            if (m_flags !== pushed[3-i] || m_depth !== 3'(3 - i)) begin
                tests_failed++;
                $display("FAIL ovf_pop%0d: flags=%b depth=%0d, expected flags=%b depth=%0d",
                         i, m_flags, m_depth, pushed[3-i], 3 - i);
            end
        end
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        check_state("ovf_clear", 2'd0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_underflow();
        drive(1'b1, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        step();
        check_state("unf_pop_empty", 2'b01, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        step();
        check_state("unf_clear", 2'b01, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        step();
        check_state("unf_set_wins", 2'b01, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step();
        step();
        check_state("b2b_depth2", 2'b01, 3'd2, 1'b0, 1'b1);
        drive(1'b1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b0);
        step();
        check_state("b2b_push_pop", 2'b11, 3'd2, 1'b0, 1'b1);
        drive(1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step();
        check_state("b2b_depth3", 2'b11, 3'd3, 1'b0, 1'b1);
        drive(1'b1, 2'b11, 2'b10, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
        check_state("b2b_reset", 2'b00, 3'd0, 1'b0, 1'b0);
        step();
        check_state("b2b_push_pop_empty", 2'b00, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        step();
        check_state("b2b_reset_discards", 2'b00, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_condition();
        a_we = 1'b1; a_mask = 4'hF; a_fin = 4'b0101;
        b_we = 1'b1; b_mask = 3'h7; b_fin = 3'b111;
        drive(1'b1, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0);
        step();
        a_we = 1'b0; b_we = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        a_sel = 2'd0; a_inv = 1'b0; #1;
        tests_run++;
        if (a_cond !== 1'b1) begin tests_failed++; $display("FAIL cond4_sel0: got %b want 1", a_cond); end
        a_sel = 2'd1; a_inv = 1'b0; #1;
        tests_run++;
        if (a_cond !== 1'b0) begin tests_failed++; $display("FAIL cond4_sel1: got %b want 0", a_cond); end
        a_sel = 2'd1; a_inv = 1'b1; #1;
        tests_run++;
        if (a_cond !== 1'b1) begin tests_failed++; $display("FAIL cond4_sel1_inv: got %b want 1", a_cond); end
        a_sel = 2'd2; a_inv = 1'b0; #1;
        tests_run++;
        if (a_cond !== 1'b1) begin tests_failed++; $display("FAIL cond4_sel2: got %b want 1", a_cond); end
        b_sel = 2'd3; b_inv = 1'b1; #1;
        tests_run++;
        if (b_cond !== 1'b0) begin tests_failed++; $display("FAIL cond3_out_of_range: got %b want 0", b_cond); end
        b_sel = 2'd2; b_inv = 1'b0; #1;
        tests_run++;
        if (b_cond !== 1'b1) begin tests_failed++; $display("FAIL cond3_sel2: got %b want 1", b_cond); end
        m_sel = 1'b1; m_inv = 1'b0; #1;
        tests_run++;
        if (m_cond !== 1'b0) begin tests_failed++; $display("FAIL cond2_sel1: got %b want 0", m_cond); end
        m_sel = 1'b0; m_inv = 1'b1; #1;
        tests_run++;
        if (m_cond !== 1'b0) begin tests_failed++; $display("FAIL cond2_sel0_inv: got %b want 0", m_cond); end
    endtask

    initial begin
        m_sel = 1'b0; m_inv = 1'b0;
        a_sel = 2'd0; a_inv = 1'b0;
        b_sel = 2'd0; b_inv = 1'b0;
        test_reset();
        test_write();
        test_push_pop_write();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_condition();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
